// File: rtl/calc_ctrl.sv
// calc_ctrl: sequencer for a small arithmetic block (add/sub, multiplier, divider).
// It registers operands, launches the selected unit and captures the result-mux
// output. It then raises a one-cycle done pulse.
// Optional build macro: CALC_CTRL_TIMEOUT_EN
//   When defined, a wait on the multiplier or divider is bounded to TIMEOUT cycles.
//   Running out of time finishes the operation with err=1 and result=0.
//   When undefined, the controller waits for the unit indefinitely and has no counter.
module calc_ctrl #(
    parameter int DATA_W  = 6,
    parameter int RES_W   = 12,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic              sub,
    output logic              mul_start,
    output logic              div_start,
    input  logic              mul_done,
    input  logic              div_done,
    output logic [1:0]        sel,
    input  logic [RES_W-1:0]  res_mux,
    output logic [RES_W-1:0]  result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Elaboration-time sanity checks on the configuration.
    if (RES_W != 2 * DATA_W) begin : g_bad_res_w
        $error("calc_ctrl: RES_W must equal 2*DATA_W");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("calc_ctrl: TIMEOUT must be at least 1");
    end

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] SEL_ADDSUB = 2'b00;
    localparam logic [1:0] SEL_MUL    = 2'b01;
    localparam logic [1:0] SEL_DIV    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_EXEC = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [DATA_W-1:0] r_opa;
    logic [DATA_W-1:0] r_opb;
    logic              r_sub;
    logic [1:0]        r_sel;
    logic [1:0]        r_op;
    logic [RES_W-1:0]  r_result;
    logic              r_err;

    logic              w_accept;
    logic              w_div_zero;
    logic              w_is_addsub;
    logic              w_sel_done;
    logic              w_timeout;
    logic [1:0]        w_sel_new;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_div_zero  = (op == OP_DIV) && (b_in == '0);
    assign w_is_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

    // Only the unit this operation launched may complete it. Stray pulses from the
    // other unit have no effect.
    assign w_sel_done = ((r_op == OP_MUL) && mul_done) ||
                        ((r_op == OP_DIV) && div_done);

`ifdef CALC_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] r_cnt;

    // Count cycles spent in WAIT. The count restarts from zero on every entry.
    always_ff @(posedge clk) begin
        if (rst || (r_state != S_WAIT)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th cycle of WAIT, so FIN follows exactly TIMEOUT cycles after entry.
    assign w_timeout = (r_state == S_WAIT) && !w_sel_done &&
                       (r_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // Select encoding for the result mux, derived from the incoming opcode.
    always_comb begin
        w_sel_new = SEL_ADDSUB;
        case (op)
            OP_MUL:  w_sel_new = SEL_MUL;
            OP_DIV:  w_sel_new = SEL_DIV;
            default: w_sel_new = SEL_ADDSUB;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    // Divide-by-zero is decided immediately. No unit is launched.
                    w_state_next = w_div_zero ? S_FIN : S_EXEC;
                end
            end
            S_EXEC:  w_state_next = w_is_addsub ? S_CAPT : S_WAIT;
            S_WAIT: begin
                if (w_sel_done || w_timeout) begin
                    w_state_next = S_FIN;
                end
            end
            S_CAPT:  w_state_next = S_FIN;
            S_FIN:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Operand/control registers load only on an accepted start.
    // They then hold until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa <= '0;
            r_opb <= '0;
            r_sub <= 1'b0;
            r_sel <= SEL_ADDSUB;
            r_op  <= OP_ADD;
        end else if (w_accept) begin
            r_opa <= a_in;
            r_opb <= b_in;
            r_sub <= (op == OP_SUB);
            r_sel <= w_sel_new;
            r_op  <= op;
        end
    end

    // Result and error flag. err is cleared by every accepted start unless that
    // operation itself fails. result changes only when a new outcome is known.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_div_zero;
            if (w_div_zero) begin
                r_result <= '1;
            end
        end else if (r_state == S_CAPT) begin
            r_result <= res_mux;
        end else if ((r_state == S_WAIT) && w_sel_done) begin
            r_result <= res_mux;
        end else if (w_timeout) begin
            r_result <= '0;
            r_err    <= 1'b1;
        end
    end

    assign opa       = r_opa;
    assign opb       = r_opb;
    assign sub       = r_sub;
    assign sel       = r_sel;
    assign result    = r_result;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign mul_start = (r_state == S_EXEC) && (r_op == OP_MUL);
    assign div_start = (r_state == S_EXEC) && (r_op == OP_DIV);

endmodule

// File: tb/tb_calc_ctrl.sv
// Scoreboard bench for calc_ctrl. Stimulus pushes a hand-computed expectation for
// each operation. A negedge monitor pops one entry for every done pulse and
// compares result, err, sel and the completion cycle.
module tb_calc_ctrl;

    localparam int DW = 6;
    localparam int RW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [DW-1:0] a_in;
    logic [DW-1:0] b_in;
    logic [DW-1:0] opa;
    logic [DW-1:0] opb;
    logic          sub;
    logic          mul_start;
    logic          div_start;
    logic          mul_done;
    logic          div_done;
    logic [1:0]    sel;
    logic [RW-1:0] res_mux;
    logic [RW-1:0] result;
    logic          busy;
    logic          done;
    logic          err;

    calc_ctrl #(.DATA_W(DW), .RES_W(RW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .a_in(a_in), .b_in(b_in), .opa(opa), .opb(opb), .sub(sub),
        .mul_start(mul_start), .div_start(div_start),
        .mul_done(mul_done), .div_done(div_done),
        .sel(sel), .res_mux(res_mux), .result(result),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [RW-1:0] result;
        logic          err;
        logic [1:0]    sel;
        int            cyc;
        string         name;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   mul_pulses = 0;
    int   div_pulses = 0;
    int   last_mul_cyc = -1;
    int   done_seen = 0;
    int   n_expected = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: count unit launches and score every done pulse.
    always @(negedge clk) begin
        if (mul_start) begin
            mul_pulses++;
            last_mul_cyc = cyc;
        end
        if (div_start) div_pulses++;
        if (!rst && done) begin
            done_seen++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk({mon_e.name, "_result"}, 32'(result), 32'(mon_e.result));
                chk({mon_e.name, "_err"}, 32'(err), 32'(mon_e.err));
                chk({mon_e.name, "_sel"}, 32'(sel), 32'(mon_e.sel));
                chk({mon_e.name, "_done_cycle"}, 32'(cyc), 32'(mon_e.cyc));
                $display("txn %s: result=0x%03h err=%0d sel=%0d done@%0d", mon_e.name, result, err, sel, cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_to(input int target);
        while (cyc < target) tick(1);
    endtask

    task automatic expect_op(input string name, input logic [RW-1:0] r, input logic e,
                             input logic [1:0] s, input int c);
        exp_t x;
        x.result = r; x.err = e; x.sel = s; x.cyc = c; x.name = name;
        sb_q.push_back(x);
        n_expected++;
    endtask

    task automatic issue(input logic [1:0] o, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output int n);
        op = o; a_in = a; b_in = b; start = 1'b1;
        n = cyc;
    endtask

    task automatic wait_idle(input string name);
        int budget = 200;
        while (sb_q.size() != 0 && budget > 0) begin
            tick(1);
            budget--;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within budget, expected done", name);
            sb_q.delete();
        end
    endtask

    initial begin
        int n;
        int mp;
        int dp;
        rst = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
        mul_done = 1'b0; div_done = 1'b0; res_mux = '0;
        tick(3);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_opa_opb", {20'd0, opa, opb}, 0);
        chk("rst_sel_sub", {29'd0, sel, sub}, 0);
        chk("rst_starts", {30'd0, mul_start, div_start}, 0);
        rst = 1'b0;
        tick(1);

        // Stray done while idle must not start anything.
        mul_done = 1'b1; div_done = 1'b1;
        tick(1);
        mul_done = 1'b0; div_done = 1'b0;
        tick(1);
        chk("idle_stray_busy", 32'(busy), 0);

        // add 25+17
        res_mux = 12'h02A;
        issue(2'b00, 6'd25, 6'd17, n);
        expect_op("add", 12'h02A, 1'b0, 2'b00, n + 3);
        tick(1);
        start = 1'b0;
        chk("add_opa", 32'(opa), 25);
        chk("add_opb", 32'(opb), 17);
        chk("add_sub", 32'(sub), 0);
        chk("add_busy", 32'(busy), 1);
        wait_idle("add");

        // mul 63*63, unit answers 6 cycles after mul_start; stray div_done meanwhile
        res_mux = '0;
        mp = mul_pulses;
        issue(2'b10, 6'd63, 6'd63, n);
        expect_op("mul", 12'hF81, 1'b0, 2'b01, n + 8);
        tick(1);
        start = 1'b0;
        chk("mul_start_pulse", 32'(mul_start), 1);
        tick_to(n + 3);
        div_done = 1'b1;
        tick(1);
        div_done = 1'b0;
        tick_to(n + 7);
        mul_done = 1'b1; res_mux = 12'hF81;
        tick(1);
        mul_done = 1'b0;
        wait_idle("mul");
        chk("mul_start_count", 32'(mul_pulses - mp), 1);
        chk("mul_start_cycle", 32'(last_mul_cyc), 32'(n + 1));

        // div 40/0
        dp = div_pulses;
        issue(2'b11, 6'd40, 6'd0, n);
        expect_op("div0", 12'hFFF, 1'b1, 2'b10, n + 1);
        tick(1);
        start = 1'b0;
        wait_idle("div0");
        tick(3);
        chk("div0_no_div_start", 32'(div_pulses - dp), 0);
        chk("div0_err_hold", 32'(err), 1);
        chk("div0_result_hold", 32'(result), 32'hFFF);

        // sub 10-20 with start re-pulsed while busy and in FIN, plus stray div_done
        mp = mul_pulses;
        res_mux = 12'hFF6;
        issue(2'b01, 6'd10, 6'd20, n);
        expect_op("sub", 12'hFF6, 1'b0, 2'b00, n + 3);
        tick(1);
        op = 2'b10; div_done = 1'b1;
        chk("sub_mode", 32'(sub), 1);
        chk("sub_err_cleared", 32'(err), 0);
        tick(1);
        start = 1'b0; div_done = 1'b0;
        tick(1);
        start = 1'b1; op = 2'b00;
        tick(1);
        start = 1'b0;
        wait_idle("sub");
        tick(4);
        chk("sub_single_op_busy", 32'(busy), 0);
        chk("sub_no_mul_launch", 32'(mul_pulses - mp), 0);

        // div 40/5, unit answers 3 cycles after div_start
        dp = div_pulses;
        res_mux = '0;
        issue(2'b11, 6'd40, 6'd5, n);
        expect_op("div", 12'h008, 1'b0, 2'b10, n + 5);
        tick(1);
        start = 1'b0;
        tick_to(n + 4);
        div_done = 1'b1; res_mux = 12'h008;
        tick(1);
        div_done = 1'b0;
        wait_idle("div");
        chk("div_start_count", 32'(div_pulses - dp), 1);

        // div abandoned by reset two cycles into WAIT; late div_done afterwards
        res_mux = 12'h123;
        issue(2'b11, 6'd40, 6'd5, n);
        tick(1);
        start = 1'b0;
        tick_to(n + 4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0; div_done = 1'b1;
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_err", 32'(err), 0);
        chk("rstmid_result", 32'(result), 0);
        chk("rstmid_opa_opb", {20'd0, opa, opb}, 0);
        chk("rstmid_sel_sub", {29'd0, sel, sub}, 0);
        tick(1);
        div_done = 1'b0;
        tick(5);
        chk("rstmid_late_done_busy", 32'(busy), 0);

`ifdef CALC_CTRL_TIMEOUT_EN
        // mul whose unit never answers: TIMEOUT=8 cycles in WAIT, then error finish
        res_mux = 12'h555;
        issue(2'b10, 6'd3, 6'd4, n);
        expect_op("mul_timeout", 12'h000, 1'b1, 2'b01, n + 10);
        tick(1);
        start = 1'b0;
        wait_idle("mul_timeout");
`endif

        tick(3);
        chk("queue_empty", 32'(sb_q.size()), 0);
        chk("done_count", 32'(done_seen), 32'(n_expected));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
